fetch_queue: RTL and testbench

Instruction fetch front-end that sits between the instruction memory and the decode/control stage of the CPU. It owns the fetch program counter, issues word-addressed requests to a variable-latency, in-order instruction memory, and buffers returned instructions in a small prefetch FIFO. Decode consumes instructions through a valid/ready handshake. Control-flow redirects flush the queue and discard in-flight responses.

---
 rtl/fetch_queue.sv | 177 +++++++++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front-end.
//
// Owns the fetch PC, issues word-addressed requests to an in-order,
// variable-latency instruction memory and buffers the returned instructions
// in a DEPTH-entry prefetch FIFO that decode drains with a valid/ready
// handshake. A redirect flushes the FIFO, restarts fetch at redirect_pc and
// discards every response still in flight at that moment.
//
// Parameters: DEPTH (FIFO entries and request credit, power of two, >= 2),
//             ADDR_W (PC width), INST_W (instruction width), RESET_PC.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   imem_req_valid/ready    request handshake, imem_req_addr = word address
//   imem_resp_valid/data    in-order responses, no backpressure
//   redirect_valid/pc       flush and restart fetch at redirect_pc
//   inst_valid/ready        decode handshake, inst_data/inst_pc = FIFO head
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   When defined, a response arriving at an empty FIFO with nothing left to
//   drop is presented to decode in the same cycle (0-cycle latency); if
//   decode takes it, it never enters the FIFO.
module fetch_queue #(
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(0)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] resp_pc_r;
  logic [CNT_W-1:0]  outstanding_r;
  logic [CNT_W-1:0]  drop_cnt_r;
  logic [CNT_W-1:0]  count_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
  logic [INST_W-1:0] inst_mem_r [DEPTH];

  logic [CNT_W:0]    credit_sum_s;
  logic              req_fire_s;
  logic              resp_keep_s;
  logic              head_valid_s;
  logic              bypass_s;
  logic              push_s;
  logic              fifo_pop_s;

  // Credit check, issue handshake and push/pop qualification.
  always_comb begin
    // Buffered entries plus in-flight requests may never exceed DEPTH, so a
    // response always finds room in the FIFO.
    credit_sum_s   = {1'b0, count_r} + {1'b0, outstanding_r};
    imem_req_valid = !reset && !redirect_valid &&
                     (credit_sum_s < (CNT_W + 1)'(DEPTH));
    imem_req_addr  = reset ? RESET_PC : fetch_pc_r;
    req_fire_s     = imem_req_valid && imem_req_ready;
    // A response in a redirect cycle belongs to the abandoned stream.
    resp_keep_s    = imem_resp_valid && (drop_cnt_r == CNT_W'(0)) && !redirect_valid;
    head_valid_s   = !reset && (count_r != CNT_W'(0));
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s       = !reset && resp_keep_s && (count_r == CNT_W'(0));
`else
    bypass_s       = 1'b0;
`endif
    // A bypassed instruction taken by decode is never written.
    push_s         = resp_keep_s && !(bypass_s && inst_ready);
    fifo_pop_s     = head_valid_s && inst_ready;
  end

  // Decode-facing outputs: FIFO head, or the live response when bypassing.
  always_comb begin
    inst_valid = head_valid_s || bypass_s;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass_s) begin
      inst_data = imem_resp_data;
      inst_pc   = resp_pc_r;
    end else begin
      inst_data = inst_mem_r[rd_ptr_r];
      inst_pc   = pc_mem_r[rd_ptr_r];
    end
`else
    inst_data  = inst_mem_r[rd_ptr_r];
    inst_pc    = pc_mem_r[rd_ptr_r];
`endif
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      pc_mem_r[wr_ptr_r]   <= resp_pc_r;
      inst_mem_r[wr_ptr_r] <= imem_resp_data;
    end
  end

  // Control state: PCs, credit counters, drop counter and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= CNT_W'(0);
      drop_cnt_r    <= CNT_W'(0);
      count_r       <= CNT_W'(0);
      wr_ptr_r      <= PTR_W'(0);
      rd_ptr_r      <= PTR_W'(0);
    end else begin
      // No request can fire in a redirect cycle, so only responses retire.
      case ({req_fire_s, imem_resp_valid})
        2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase

      if (redirect_valid) begin
        // Everything still in flight after this cycle is stale.
        drop_cnt_r <= outstanding_r - CNT_W'(imem_resp_valid);
        fetch_pc_r <= redirect_pc;
        resp_pc_r  <= redirect_pc;
        count_r    <= CNT_W'(0);
        wr_ptr_r   <= PTR_W'(0);
        rd_ptr_r   <= PTR_W'(0);
      end else begin
        if (imem_resp_valid && (drop_cnt_r != CNT_W'(0))) begin
          drop_cnt_r <= drop_cnt_r - CNT_W'(1);
        end else begin
          drop_cnt_r <= drop_cnt_r;
        end

        if (req_fire_s) begin
          fetch_pc_r <= fetch_pc_r + ADDR_W'(1);
        end else begin
          fetch_pc_r <= fetch_pc_r;
        end

        if (resp_keep_s) begin
          resp_pc_r <= resp_pc_r + ADDR_W'(1);
        end else begin
          resp_pc_r <= resp_pc_r;
        end

        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end

        if (fifo_pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end

        case ({push_s, fifo_pop_s})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          ADDR_W   = 32;
  localparam int          INST_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          N_CYC    = 3000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit          BYP      = 1'b1;
`else
  localparam bit          BYP      = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  fetch_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected decode stream entry; cyc is the cycle its response arrived.
  typedef struct { logic [31:0] pc; logic [31:0] data; int cyc; } exp_t;
  // Request held by the memory model; epoch marks the fetch stream it belongs to.
  typedef struct { logic [31:0] addr; int due; int epoch; } req_t;

  exp_t        scb[$];
  req_t        pend[$];
  int          cyc, epoch, last_due, lat_max, p_rr, p_ir;
  int          n_checks, n_fail;
  logic [31:0] exp_fetch_pc, exp_resp_pc;
  bit          resp_now, done, prev_redir;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h0000_0100;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares request addresses, valids and decode pops mid-cycle.
  initial begin
    int   old_n;
    bit   exp_iv, exp_rv;
    exp_t h;
    req_t q;
    while (!done) begin
      @(negedge clk);
      if (done) break;
      if (reset) begin
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        check("rst_req_addr", {32'd0, imem_req_addr}, {32'd0, RESET_PC});
      end else begin
        old_n = 0;
        foreach (scb[i]) if (scb[i].cyc < cyc) old_n++;
        exp_iv = (scb.size() > 0) && (BYP || (scb[0].cyc < cyc));
        check("inst_valid", {63'd0, inst_valid}, {63'd0, exp_iv});
        exp_rv = !redirect_valid && ((pend.size() + int'(resp_now) + old_n) < DEPTH);
        check("req_valid", {63'd0, imem_req_valid}, {63'd0, exp_rv});
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", {32'd0, imem_req_addr}, {32'd0, exp_fetch_pc});
          q.addr  = imem_req_addr;
          q.due   = cyc + $urandom_range(1, lat_max);
          if (q.due <= last_due) q.due = last_due + 1;
          last_due = q.due;
          q.epoch = epoch;
          pend.push_back(q);
          exp_fetch_pc = exp_fetch_pc + 32'd1;
        end
        if (inst_valid && inst_ready) begin
          if (scb.size() == 0) begin
            check("unexpected_pop", 64'd1, 64'd0);
          end else begin
            h = scb.pop_front();
            check("inst_pc", {32'd0, inst_pc}, {32'd0, h.pc});
            check("inst_data", {32'd0, inst_data}, {32'd0, h.data});
          end
        end
      end
    end
  end

  // Driver and memory model: phases, redirects, resets and in-order responses.
  initial begin
    bit          do_rst, do_redir;
    logic [31:0] tgt;
    req_t        r;
    exp_t        e;
    n_checks = 0; n_fail = 0; done = 1'b0; prev_redir = 1'b0;
    epoch = 0; last_due = 0; cyc = 0; resp_now = 1'b0;
    lat_max = 1; p_rr = 100; p_ir = 100;
    exp_fetch_pc = RESET_PC; exp_resp_pc = RESET_PC;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    inst_ready = 1'b1;
    for (int c = 0; c < N_CYC; c++) begin
      @(posedge clk); #1;
      cyc = c;
      do_redir = 1'b0;
      tgt      = 32'd0;
      if      (c < 60)  begin lat_max = 1; p_rr = 100; p_ir = 100; end
      else if (c < 100) begin lat_max = 2; p_rr = 100; p_ir = 0;   end
      else if (c < 140) begin lat_max = 3; p_rr = 100; p_ir = 50;  end
      else if (c < 146) begin lat_max = 2; p_rr = 0;   p_ir = 100; end
      else if (c < 160) begin lat_max = 2; p_rr = 100; p_ir = 100; end
      else if (c < 180) begin lat_max = 2; p_rr = 100; p_ir = 0;   end
      else if (c < 200) begin lat_max = 1; p_rr = 100; p_ir = 100; end
      else              begin lat_max = 4; p_rr = 70;  p_ir = 70;  end
      if (c == 110) begin do_redir = 1'b1; tgt = 32'h0000_0040; end
      if (c == 185) begin do_redir = 1'b1; tgt = 32'hFFFF_FFFD; end
      if (c == 300 || c == 301) begin do_redir = 1'b1; tgt = 32'h0000_1000 + c; end
      if (c > 200 && $urandom_range(0, 99) < 3) begin do_redir = 1'b1; tgt = $urandom; end
      do_rst = (c < 3) || (c == 175) || (c > 200 && $urandom_range(0, 999) < 5);

      if (prev_redir) begin
        scb.delete();
        prev_redir = 1'b0;
      end
      resp_now        = 1'b0;
      imem_resp_valid = 1'b0;
      if (do_rst) begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        pend.delete();
        scb.delete();
        epoch++;
        last_due       = c;
        exp_fetch_pc   = RESET_PC;
        exp_resp_pc    = RESET_PC;
      end else begin
        reset = 1'b0;
        if (pend.size() > 0 && pend[0].due <= c) begin
          r = pend.pop_front();
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(r.addr);
          resp_now        = 1'b1;
          if (!do_redir && r.epoch == epoch) begin
            e.pc   = exp_resp_pc;
            e.data = mem_word(exp_resp_pc);
            e.cyc  = c;
            scb.push_back(e);
            exp_resp_pc = exp_resp_pc + 32'd1;
          end
        end
        redirect_valid = do_redir;
        if (do_redir) begin
          redirect_pc  = tgt;
          epoch++;
          exp_fetch_pc = tgt;
          exp_resp_pc  = tgt;
          prev_redir   = 1'b1;
        end
      end
      imem_req_ready = ($urandom_range(1, 100) <= p_rr);
      inst_ready     = ($urandom_range(1, 100) <= p_ir);
    end
    @(posedge clk); #1;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
